path_replayer: RTL
==================

Name: path_replayer

Overview:
- Downstream consumer of the maze solver's path queue.
- The solver's FIFO_MAKER stage fills the queue by popping the move stack, so the queue delivers the solution path last-move-first.
- This block dequeues one 2-bit move per step and applies its inverse, walking the rat from the goal (MAX,MAX) back to the origin (0,0).
- It emits a paced, timestamped coordinate stream for display/checking and flags malformed paths.

Parameters:
- COORD_W, 4, width of x/y coordinate; MAX = 2^COORD_W-1.
- HOLD_CYCLES, 4, cycles each position is held after a step (>=1).
- CNT_W, 8, width of step counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  pulse; begins a replay when not busy
- q_empty  input  1  path queue empty flag
- q_data  input  2  queue head data, valid the cycle after q_deq
- q_deq  output  1  one-cycle dequeue request
- cur_x  output  COORD_W  current replay x
- cur_y  output  COORD_W  current replay y
- step_valid  output  1  one-cycle pulse when a new position first appears on cur_x/cur_y
- step_count  output  CNT_W  moves applied since start
- busy  output  1  high in any state other than IDLE/DONE/ERR
- path_done  output  1  sticky; replay ended on an empty queue
- path_err  output  1  sticky; bad path detected

Behaviour:
- Opcode encoding (shared with the move translator): 00 = x+1, 01 = y+1, 10 = x-1, 11 = y-1.
- The replayer applies the inverse of each opcode: 00 -> x-1, 01 -> y-1, 10 -> x+1, 11 -> y+1.
- Reset values:
  - cur_x = cur_y = MAX; step_count = 0.
  - q_deq, step_valid, busy, path_done, path_err = 0.
  - State IDLE, hold counter 0.
- Reset mid-replay aborts immediately to these values. A pending dequeued word is discarded.
- States:
  - IDLE, DONE, ERR: start=1 -> reload cur_x/cur_y = MAX, clear step_count, path_done and path_err, go to REQ. Otherwise stay.
  - REQ: if q_empty, go to DONE, set path_done=1, and set path_err=1 if (cur_x,cur_y) != (0,0). Else assert q_deq for this cycle only and go to CAP.
  - CAP: register q_data into the move register; go to STEP.
  - STEP: compute the inverse move.
    - If the result leaves [0,MAX] on either axis: position unchanged, path_err=1, go to ERR.
    - Else: register the new position, increment step_count (saturating at 2^CNT_W-1), load the hold counter with HOLD_CYCLES-1, go to HOLD.
  - HOLD: step_valid=1 on the first HOLD cycle only. Decrement the hold counter; at 0 go to REQ.
- Timing:
  - start sampled at cycle t gives q_deq at t+1 and a new position plus step_valid at t+4.
  - Steady-state period is 3+HOLD_CYCLES cycles per move.
- start while busy is ignored. q_empty is only sampled in REQ.
- q_deq is never asserted when q_empty=1, nor outside REQ.
- DONE and ERR hold all outputs stable until start or rst.
- Underflow/overflow is checked per axis with COORD_W+1-bit arithmetic. There is no wrap-around.

Test Plan:
- Reset then idle: rst pulse, no start -> cur=(15,15), step_count=0, q_deq never high, busy=0.
- Empty queue: start with q_empty=1 -> DONE 2 cycles later; path_done=1, path_err=1 (position is (15,15), not origin); no q_deq.
- Valid path: queue holds 15×00 then 15×01 (last-move-first), HOLD_CYCLES=4.
  - Walk goes (14,15)…(0,15)…(0,0); step_valid pulses every 7 cycles.
  - Ends with step_count=30, path_done=1, path_err=0.
- Out-of-bounds: first queued move is 10 (inverse x+1 from x=15) -> ERR; cur stays (15,15); path_err=1; step_count=0; no further q_deq.
- Reset mid-operation: assert rst during HOLD after 5 steps -> all outputs return to reset values immediately; a following start replays from (15,15) with step_count restarting at 0.
- Start while busy: a second start pulse during HOLD -> no state change; step_count and position sequence identical to a single-start run.

Source files
------------

// File: rtl/path_replayer.sv
// Replays a solved maze path from the goal back to the origin.
// Each dequeued move is applied in reverse, and every new position is held for a fixed number of cycles.
module path_replayer #(
    parameter int unsigned COORD_W     = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               q_empty,
    input  logic [1:0]         q_data,
    output logic               q_deq,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               step_valid,
    output logic [CNT_W-1:0]   step_count,
    output logic               busy,
    output logic               path_done,
    output logic               path_err
);

    localparam int unsigned EXT_W  = COORD_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [COORD_W-1:0] MAX     = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [HOLD_W-1:0]  HOLD_LD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_STEP,
        S_HOLD,
        S_DONE,
        S_ERR
    } state_e;

    state_e              state_q;
    logic [COORD_W-1:0]  x_q;
    logic [COORD_W-1:0]  y_q;
    logic [1:0]          move_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                step_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [EXT_W-1:0]    nx_c;
    logic [EXT_W-1:0]    ny_c;
    logic                oob_c;

    // Inverse move with one extra bit so under/overflow lands in the MSB
    always_comb begin
        nx_c = {1'b0, x_q};
        ny_c = {1'b0, y_q};
        case (move_q)
            2'b00:   nx_c = {1'b0, x_q} - EXT_W'(1);
            2'b01:   ny_c = {1'b0, y_q} - EXT_W'(1);
            2'b10:   nx_c = {1'b0, x_q} + EXT_W'(1);
            default: ny_c = {1'b0, y_q} + EXT_W'(1);
        endcase
    end

    assign oob_c = nx_c[COORD_W] | ny_c[COORD_W];

    // Dequeue must follow q_empty within the same REQ cycle
    assign q_deq = (state_q == S_REQ) && !q_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= MAX;
            y_q          <= MAX;
            move_q       <= 2'b00;
            cnt_q        <= '0;
            hold_q       <= '0;
            step_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            step_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        x_q     <= MAX;
                        y_q     <= MAX;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (q_empty) begin
                        done_q  <= 1'b1;
                        err_q   <= (x_q != '0) || (y_q != '0);
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_CAP;
                    end
                end
                S_CAP: begin
                    move_q  <= q_data;
                    state_q <= S_STEP;
                end
                S_STEP: begin
                    if (oob_c) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_ERR;
                    end else begin
                        x_q          <= nx_c[COORD_W-1:0];
                        y_q          <= ny_c[COORD_W-1:0];
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        hold_q       <= HOLD_LD;
                        step_valid_q <= 1'b1;
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_q == '0) begin
                        state_q <= S_REQ;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cur_x      = x_q;
    assign cur_y      = y_q;
    assign step_valid = step_valid_q;
    assign step_count = cnt_q;
    assign busy       = busy_q;
    assign path_done  = done_q;
    assign path_err   = err_q;

endmodule
